rr_req_queue: RTL and testbench

- Front-end/back-end companion to the N-way round-robin arbiter.
- Holds a small FIFO per requester and drives the arbiter's req vector from FIFO occupancy.
- Consumes the arbiter's registered one-hot grant, pops the granted FIFO, and forwards the entry with its source index through a 2-entry output buffer with a valid/ready handshake.
- Sits between N producer ports and one shared consumer.

---
 rtl/rr_req_queue_if.sv | 27 ++
 rtl/rr_req_queue.sv | 136 +++++++++++++
 tb/tb_rr_req_queue.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_req_queue_if.sv
// Producer/arbiter/consumer bundle for rr_req_queue; the queue itself uses the slave view.
interface rr_req_queue_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int SW = 2
);
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic            err;

    modport slave (
        input  in_valid, in_data, grant, out_ready,
        output in_ready, req, out_valid, out_data, out_src, err
    );

    modport master (
        output in_valid, in_data, grant, out_ready,
        input  in_ready, req, out_valid, out_data, out_src, err
    );
endinterface

// File: rtl/rr_req_queue.sv
// Per-requester FIFOs feeding a round-robin arbiter; granted heads are tagged with their
// source index and forwarded through a 2-entry credit-protected output buffer.
module rr_req_queue #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int SW    = 2
) (
    input  logic          clk,
    input  logic          rst_an,
    rr_req_queue_if.slave bus
);
    localparam logic [AW:0]  FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [N-1:0] GRANT_ONE = N'(1);

    logic [N-1:0]  nonempty;
    logic [N-1:0]  pop_fifo;
    logic [N-1:0]  in_ready_w;
    logic [N-1:0]  req_raw;
    logic [N-1:0]  req_w;
    logic [DW-1:0] head_data [N];

    logic          grant_multi;
    logic          grant_ok;
    logic          grant_hit;
    logic          grant_empty;
    logic [SW-1:0] grant_idx;
    logic [DW-1:0] grant_data;

    logic          req_en;
    logic          out_pop;
    logic          ob_full;
    logic          ob_push;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic          ob_wr_q;
    logic          ob_rd_q;
    logic [DW-1:0] ob_data_q [2];
    logic [SW-1:0] ob_src_q  [2];
    logic          inflight_q;
    logic          err_q;
    logic          err_d;

    assign grant_multi = (bus.grant & (bus.grant - GRANT_ONE)) != '0;
    assign grant_ok    = (bus.grant != '0) & ~grant_multi;
    assign grant_hit   = grant_ok & ((bus.grant & nonempty) != '0);
    assign grant_empty = grant_ok & ((bus.grant & nonempty) == '0);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i]) grant_idx = SW'(i);
        end
    end

    assign grant_data = head_data[grant_idx];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fifo
            logic [DW-1:0] mem_q [DEPTH];
            logic [AW-1:0] wr_ptr_q;
            logic [AW-1:0] rd_ptr_q;
            logic [AW:0]   count_q;
            logic [AW:0]   count_d;
            logic          push;

            assign push           = bus.in_valid[gi] & in_ready_w[gi];
            assign pop_fifo[gi]   = grant_ok & bus.grant[gi] & nonempty[gi];
            assign in_ready_w[gi] = (count_q != FULL_CNT);
            assign nonempty[gi]   = (count_q != '0);
            // An entry granted this cycle is already spoken for, so it no longer counts as a request.
            assign req_raw[gi]    = (count_q - {{AW{1'b0}}, bus.grant[gi]}) != '0;
            assign head_data[gi]  = mem_q[rd_ptr_q];
            assign count_d        = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_fifo[gi]};

            always_ff @(posedge clk) begin
                if (push) mem_q[wr_ptr_q] <= bus.in_data[gi*DW +: DW];
            end

            always_ff @(posedge clk or negedge rst_an) begin
                if (!rst_an) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push)         wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop_fifo[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
                    count_q <= count_d;
                end
            end
        end
    endgenerate

    // Buffer slots plus the single grant that may still be in flight act as credits.
    assign req_en  = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
    assign req_w   = {N{rst_an & req_en}} & req_raw;

    assign out_pop = (occ_q != 2'd0) & bus.out_ready;
    assign ob_full = (occ_q == 2'd2) & ~out_pop;
    assign ob_push = grant_hit & ~ob_full;
    assign occ_d   = occ_q + {1'b0, ob_push} - {1'b0, out_pop};
    assign err_d   = err_q | grant_multi | grant_empty | (grant_hit & ob_full);

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            occ_q      <= '0;
            ob_wr_q    <= 1'b0;
            ob_rd_q    <= 1'b0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                ob_data_q[k] <= '0;
                ob_src_q[k]  <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            err_q      <= err_d;
            inflight_q <= |req_w;
            if (ob_push) begin
                ob_data_q[ob_wr_q] <= grant_data;
                ob_src_q[ob_wr_q]  <= grant_idx;
                ob_wr_q            <= ~ob_wr_q;
            end
            if (out_pop) ob_rd_q <= ~ob_rd_q;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.req       = req_w;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = ob_data_q[ob_rd_q];
    assign bus.out_src   = ob_src_q[ob_rd_q];
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rr_req_queue.sv
// Bench for rr_req_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model; an in-bench round-robin arbiter drives grant.
module tb_rr_req_queue;
    localparam int N = 4, DW = 8, DEPTH = 4, AW = 2, SW = 2;

    logic clk = 1'b0;
    logic rst_an;
    always #5 clk = ~clk;

    rr_req_queue_if #(.N(N), .DW(DW), .SW(SW)) bus ();

    rr_req_queue #(.N(N), .DW(DW), .DEPTH(DEPTH), .AW(AW), .SW(SW)) dut (
        .clk   (clk),
        .rst_an(rst_an),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0]    mq [N][$];
    logic [SW+DW-1:0] oq [$];
    logic [SW+DW-1:0] seen [$];
    logic [N-1:0]     glog [$];
    int               m_inflight;
    bit               m_err;
    logic [N-1:0]     m_req;
    logic [N-1:0]     arb_next;
    int               arb_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] mkd(input int i, input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        r = '0;
        r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit model_pending();
        bit p;
        p = (oq.size() != 0);
        for (int i = 0; i < N; i++) if (mq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        oq.delete();
        m_inflight = 0;
        m_err      = 1'b0;
        m_req      = '0;
        arb_next   = '0;
        arb_last   = N - 1;
    endtask

    task automatic check_model();
        logic [N-1:0]     e_rdy;
        logic [SW+DW-1:0] h;
        bit               en;
        en = (oq.size() + m_inflight) < 2;
        for (int i = 0; i < N; i++) begin
            e_rdy[i] = (mq[i].size() < DEPTH);
            m_req[i] = en && ((mq[i].size() - int'(bus.grant[i])) != 0);
        end
        chk("in_ready", bus.in_ready, e_rdy);
        chk("req", bus.req, m_req);
        chk("out_valid", bus.out_valid, oq.size() != 0);
        chk("err", bus.err, m_err);
        if (oq.size() != 0) begin
            h = oq[0];
            chk("out_data", bus.out_data, h[DW-1:0]);
            chk("out_src", bus.out_src, h[SW+DW-1:DW]);
        end
        if (bus.out_valid && bus.out_ready) seen.push_back({bus.out_src, bus.out_data});
        if (bus.grant != '0) glog.push_back(bus.grant);
        arb_next = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (arb_last + k) % N;
            if (arb_next == '0 && m_req[j] && !bus.grant[j]) begin
                arb_next[j] = 1'b1;
                arb_last    = j;
            end
        end
    endtask

    task automatic model_update();
        int ob0, idx, ng;
        bit opop, opush;
        bit acc [N];
        logic [DW-1:0] d;
        ob0  = oq.size();
        opop = (ob0 > 0) && bus.out_ready;
        for (int i = 0; i < N; i++) acc[i] = bus.in_valid[i] && (mq[i].size() < DEPTH);
        ng = $countones(bus.grant);
        opush = 1'b0;
        idx = 0;
        d = '0;
        if (ng > 1) m_err = 1'b1;
        else if (ng == 1) begin
            idx = oh2idx(bus.grant);
            if (mq[idx].size() == 0) m_err = 1'b1;
            else begin
                d = mq[idx].pop_front();
                if (ob0 == 2 && !opop) m_err = 1'b1;
                else opush = 1'b1;
            end
        end
        if (opop) void'(oq.pop_front());
        if (opush) oq.push_back({idx[SW-1:0], d});
        for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(bus.in_data[i*DW +: DW]);
        m_inflight = (m_req != '0) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic [N-1:0] g, input bit auto_g, input logic ordy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.grant     = auto_g ? arb_next : g;
        bus.out_ready = ordy;
        #1;
        check_model();
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic [N-1:0] g, input bit auto_g, input logic ordy);
        drive(v, d, g, auto_g, ordy);
        tick();
    endtask

    task automatic rst_checks(input string p);
        chk({p, "_out_valid"}, bus.out_valid, 0);
        chk({p, "_req"}, bus.req, 0);
        chk({p, "_in_ready"}, bus.in_ready, 4'b1111);
        chk({p, "_err"}, bus.err, 0);
        chk({p, "_out_data"}, bus.out_data, 0);
        chk({p, "_out_src"}, bus.out_src, 0);
    endtask

    task automatic reset_dut(input logic [N-1:0] g);
        bus.grant    = g;
        bus.in_valid = '0;
        rst_an       = 1'b0;
        #1;
        rst_checks("rst_now");
        model_reset();
        @(posedge clk);
        #1;
        rst_checks("rst_hold");
        @(negedge clk);
        bus.grant = '0;
        rst_an    = 1'b1;
    endtask

    task automatic drain();
        for (int c = 0; c < 80 && model_pending(); c++) cyc('0, '0, '0, 1'b1, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b1);
        chk("drained_out_valid", bus.out_valid, 0);
        tick();
    endtask

    initial begin
        logic [N*DW-1:0] dall;
        logic [SW+DW-1:0] s;
        int nxt;

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.grant     = '0;
        bus.out_ready = 1'b0;
        seen.delete();
        glog.delete();
        reset_dut('0);

        // Single entry on requester 2
        cyc(4'b0100, mkd(2, 8'hA5), '0, 1'b0, 1'b1);
        drive('0, '0, '0, 1'b0, 1'b1);
        chk("A_req_c1", bus.req, 4'b0100);
        tick();
        drive('0, '0, 4'b0100, 1'b0, 1'b1);
        chk("A_req_c2", bus.req, 4'b0000);
        tick();
        drive('0, '0, '0, 1'b0, 1'b1);
        chk("A_out_valid", bus.out_valid, 1);
        chk("A_out_data", bus.out_data, 8'hA5);
        chk("A_out_src", bus.out_src, 2);
        chk("A_err", bus.err, 0);
        tick();

        // Fill requester 0, then drain with refill across the pointer wrap
        for (int k = 0; k < 6; k++) begin
            drive(4'b0001, mkd(0, DW'(k)), '0, 1'b0, 1'b1);
            if (k >= 4) chk("B_in_ready_full", bus.in_ready[0], 0);
            tick();
        end
        seen.delete();
        nxt = 4;
        for (int c = 0; c < 60 && seen.size() < 8; c++) begin
            if (nxt < 8 && mq[0].size() < DEPTH) begin
                cyc(4'b0001, mkd(0, DW'(nxt)), '0, 1'b1, 1'b1);
                nxt++;
            end else cyc('0, '0, '0, 1'b1, 1'b1);
        end
        chk("B_count", seen.size(), 8);
        for (int k = 0; k < seen.size(); k++) begin
            s = seen[k];
            chk("B_order", s[DW-1:0], k);
        end
        drain();

        // Backpressure: everything loaded, consumer stalled, arbiter free-running
        for (int k = 0; k < 2; k++) begin
            dall = '0;
            for (int i = 0; i < N; i++) dall[i*DW +: DW] = DW'(8'h10 * i + k);
            cyc(4'b1111, dall, '0, 1'b0, 1'b0);
        end
        seen.delete();
        glog.delete();
        for (int c = 0; c < 12; c++) cyc('0, '0, '0, 1'b1, 1'b0);
        drive('0, '0, '0, 1'b1, 1'b0);
        chk("C_sat_req", bus.req, 0);
        chk("C_sat_valid", bus.out_valid, 1);
        tick();
        for (int c = 0; c < 80 && seen.size() < 8; c++) cyc('0, '0, '0, 1'b1, 1'b1);
        chk("C_count", seen.size(), 8);
        for (int k = 0; k < seen.size() && k < glog.size(); k++) begin
            s = seen[k];
            chk("C_src_order", s[SW+DW-1:DW], oh2idx(glog[k]));
        end
        drain();

        // Output pop, grant and write to the same FIFO in one cycle
        seen.delete();
        cyc(4'b1000, mkd(3, 8'hD0), '0, 1'b0, 1'b0);
        cyc(4'b1000, mkd(3, 8'hD1), '0, 1'b0, 1'b0);
        cyc('0, '0, 4'b1000, 1'b0, 1'b0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        drive(4'b1000, mkd(3, 8'hD2), 4'b1000, 1'b0, 1'b1);
        chk("D_pre_valid", bus.out_valid, 1);
        tick();
        drive('0, '0, '0, 1'b0, 1'b0);
        chk("D_valid", bus.out_valid, 1);
        chk("D_data", bus.out_data, 8'hD1);
        chk("D_src", bus.out_src, 3);
        tick();
        drain();
        chk("D_count", seen.size(), 3);
        for (int k = 0; k < seen.size(); k++) begin
            s = seen[k];
            chk("D_seq", s[DW-1:0], 8'hD0 + k);
        end

        // Grant to an empty FIFO
        cyc('0, '0, 4'b0010, 1'b0, 1'b0);
        drive('0, '0, '0, 1'b0, 1'b0);
        chk("E_empty_err", bus.err, 1);
        chk("E_empty_valid", bus.out_valid, 0);
        tick();
        reset_dut('0);

        // Multi-hot grant pops nothing
        cyc(4'b0011, mkd(0, 8'hE0) | mkd(1, 8'hE1), '0, 1'b0, 1'b0);
        cyc('0, '0, 4'b0011, 1'b0, 1'b0);
        drive('0, '0, '0, 1'b0, 1'b0);
        chk("E_multi_err", bus.err, 1);
        chk("E_multi_valid", bus.out_valid, 0);
        tick();

        // Reset in the middle of traffic with a grant present
        cyc(4'b1100, mkd(2, 8'hF2) | mkd(3, 8'hF3), '0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) cyc('0, '0, '0, 1'b1, 1'b0);
        drive('0, '0, '0, 1'b0, 1'b0);
        chk("F_pre_valid", bus.out_valid, 1);
        chk("F_pre_err", bus.err, 1);
        reset_dut(4'b0001);
        for (int c = 0; c < 3; c++) begin
            drive('0, '0, '0, 1'b0, 1'b1);
            chk("F_post_valid", bus.out_valid, 0);
            chk("F_post_req", bus.req, 0);
            chk("F_post_in_ready", bus.in_ready, 4'b1111);
            chk("F_post_err", bus.err, 0);
            tick();
        end

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            cyc(N'($urandom), (N*DW)'({$urandom, $urandom}), '0, 1'b1,
                $urandom_range(0, 3) != 0);
        end
        drain();
        drive('0, '0, '0, 1'b0, 1'b1);
        chk("G_err", bus.err, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
